// File: rtl/cnt_ctrl_pkg.sv
// Shared state encoding and default widths for the counter run controller.
package cnt_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_PRE_W = 4;
  // Width of the count/terminal comparison, and the default counter width.
  localparam int TC_CMP_W  = DEF_WIDTH;

endpackage

// File: rtl/cnt_prescaler.sv
// Prescale counter: produces a tick every (period_i+1) running, unfrozen cycles.
module cnt_prescaler
  import cnt_ctrl_pkg::*;
#(
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             run_i,
  input  logic             freeze_i,
  input  logic [PRE_W-1:0] period_i,
  output logic             tick_o
);

  logic [PRE_W-1:0] pre_cnt_q;
  logic [PRE_W-1:0] pre_cnt_d;

  assign tick_o = run_i && !freeze_i && (pre_cnt_q == period_i);

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (load_i) begin
      pre_cnt_d = '0;
    end else if (tick_o) begin
      pre_cnt_d = '0;
    end else if (run_i && !freeze_i) begin
      pre_cnt_d = pre_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/counter_run_ctrl.sv
// Run controller for the enabled up-counter: start/pause/stop with a done pulse.
// Define CNT_CTRL_AUTO_RELOAD_EN to add the auto_reload input (restart at terminal count).
module counter_run_ctrl
  import cnt_ctrl_pkg::*;
#(
  parameter int WIDTH = TC_CMP_W,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [WIDTH-1:0] term_cnt,
  input  logic [PRE_W-1:0] prescale,
`ifdef CNT_CTRL_AUTO_RELOAD_EN
  input  logic             auto_reload,
`endif
  output logic [WIDTH-1:0] count,
  output logic             count_enb,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             done_q, done_d;
  logic             tick;
  logic             accept;
  logic             at_term;
  logic             running;
  logic             reload_en;
  logic             finish;

`ifdef CNT_CTRL_AUTO_RELOAD_EN
  assign reload_en = auto_reload;
`else
  assign reload_en = 1'b0;
`endif

  assign running = (state_q != ST_IDLE);
  assign accept  = (state_q == ST_IDLE) && start && !stop;
  assign at_term = (count_q == term_q);
  // Terminal tick that ends the run (a reloading run keeps going).
  assign finish  = tick && at_term && !reload_en;

  cnt_prescaler #(
    .PRE_W(PRE_W)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .load_i   (accept),
    .run_i    (running),
    .freeze_i (pause || stop),
    .period_i (pre_q),
    .tick_o   (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stop)        state_d = ST_IDLE;
        else if (pause)  state_d = ST_PAUSE;
        else if (finish) state_d = ST_IDLE;
      end
      ST_PAUSE: begin
        // Releasing pause resumes immediately, so that cycle may already tick.
        if (stop)        state_d = ST_IDLE;
        else if (pause)  state_d = ST_PAUSE;
        else if (finish) state_d = ST_IDLE;
        else             state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = running;
    count_enb = tick;
    count     = count_q;
    done      = done_q;
  end

  always_comb begin
    count_d = count_q;
    term_d  = term_q;
    pre_d   = pre_q;
    done_d  = 1'b0;
    if (accept) begin
      term_d  = term_cnt;
      pre_d   = prescale;
      count_d = '0;
    end else if (tick) begin
      if (at_term) begin
        done_d = 1'b1;
        if (reload_en) count_d = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
      term_q  <= '0;
      pre_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      term_q  <= term_d;
      pre_q   <= pre_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Self-checking bench for counter_run_ctrl: vector table, corner sequences, random run.
module tb_counter_run_ctrl;

  localparam int WIDTH = 8;
  localparam int PRE_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             pause = 1'b0;
  logic [WIDTH-1:0] term_cnt = '0;
  logic [PRE_W-1:0] prescale = '0;
  bit               ar_drv = 1'b0;
  logic [WIDTH-1:0] count;
  logic             count_enb;
  logic             busy;
  logic             done;

  counter_run_ctrl #(
    .WIDTH(WIDTH),
    .PRE_W(PRE_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .term_cnt  (term_cnt),
    .prescale  (prescale),
`ifdef CNT_CTRL_AUTO_RELOAD_EN
    .auto_reload(ar_drv),
`endif
    .count     (count),
    .count_enb (count_enb),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
  endtask

  // Reference model: a run is the number of unpaused active cycles elapsed;
  // count and tick follow from that by division.
  bit m_active  = 1'b0;
  bit m_done    = 1'b0;
  int m_term    = 0;
  int m_per     = 0;
  int m_elapsed = 0;
  int m_held    = 0;

  function automatic int m_count();
    return m_active ? (m_elapsed / (m_per + 1)) : m_held;
  endfunction

  function automatic bit m_tick();
    return m_active && !pause && !stop && ((m_elapsed % (m_per + 1)) == m_per);
  endfunction

  task automatic model_edge();
    if (!reset) begin
      m_active = 0; m_done = 0; m_term = 0; m_per = 0; m_elapsed = 0; m_held = 0;
    end else if (!m_active) begin
      m_done = 0;
      if (start && !stop) begin
        m_active = 1; m_term = int'(term_cnt); m_per = int'(prescale); m_elapsed = 0;
      end
    end else if (stop) begin
      m_held = m_count(); m_active = 0; m_done = 0;
    end else if (pause) begin
      m_done = 0;
    end else if (m_tick() && m_count() == m_term) begin
      m_done = 1;
      if (ar_drv) m_elapsed = 0;
      else begin m_active = 0; m_held = m_term; end
    end else begin
      m_elapsed++; m_done = 0;
    end
  endtask

  task automatic step(input bit r, input bit s, input bit sp, input bit pa,
                      input int t, input int pr);
    @(posedge clk); #1;
    reset = r; start = s; stop = sp; pause = pa;
    term_cnt = WIDTH'(t); prescale = PRE_W'(pr);
    @(negedge clk);
    check("model_count", int'(count), m_count());
    check("model_count_enb", int'(count_enb), int'(m_tick()));
    check("model_busy", int'(busy), int'(m_active));
    check("model_done", int'(done), int'(m_done));
    model_edge();
  endtask

  typedef struct {
    bit r; bit s; bit sp; bit pa; int t; int pr;
    int c; int e; int b; int d;
  } vec_t;

  vec_t tbl[24];
  int   edges;
  int   pulses;

  initial begin
    // inputs        r  s  sp pa t  pr | count enb busy done
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 1, 0, 0, 5, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    tbl[5]  = '{1, 0, 0, 0, 0, 0, 1, 1, 1, 0};
    tbl[6]  = '{1, 0, 0, 0, 0, 0, 2, 1, 1, 0};
    tbl[7]  = '{1, 0, 0, 0, 0, 0, 3, 1, 1, 0};
    tbl[8]  = '{1, 0, 0, 0, 0, 0, 4, 1, 1, 0};
    tbl[9]  = '{1, 0, 0, 0, 0, 0, 5, 1, 1, 0};
    tbl[10] = '{1, 0, 0, 0, 0, 0, 5, 0, 0, 1};
    tbl[11] = '{1, 0, 0, 0, 0, 0, 5, 0, 0, 0};
    tbl[12] = '{1, 1, 0, 0, 0, 0, 5, 0, 0, 0};
    tbl[13] = '{1, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    tbl[14] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[15] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[16] = '{1, 1, 1, 0, 9, 0, 0, 0, 0, 0};
    tbl[17] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[18] = '{1, 1, 0, 0, 9, 1, 0, 0, 0, 0};
    tbl[19] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    tbl[20] = '{1, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    tbl[21] = '{1, 0, 0, 0, 0, 0, 1, 0, 1, 0};
    tbl[22] = '{1, 0, 1, 0, 0, 0, 1, 0, 1, 0};
    tbl[23] = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0};

    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      reset = tbl[i].r; start = tbl[i].s; stop = tbl[i].sp; pause = tbl[i].pa;
      term_cnt = WIDTH'(tbl[i].t); prescale = PRE_W'(tbl[i].pr);
      @(negedge clk);
      check($sformatf("row%0d_count", i), int'(count), tbl[i].c);
      check($sformatf("row%0d_count_enb", i), int'(count_enb), tbl[i].e);
      check($sformatf("row%0d_busy", i), int'(busy), tbl[i].b);
      check($sformatf("row%0d_done", i), int'(done), tbl[i].d);
      $display("row %0d: count=%0d enb=%0d busy=%0d done=%0d", i, count, count_enb, busy, done);
      model_edge();
    end

    // term=3, prescale=2, with a conflicting start while busy.
    step(1, 1, 0, 0, 3, 2);
    edges = -1;
    for (int k = 1; k <= 40 && edges < 0; k++) begin
      step(1, k == 2, 0, 0, (k == 2) ? 7 : 0, 0);
      if (done) edges = k - 1;
    end
    check("prescale_done_edge", edges, 12);
    check("prescale_final_count", int'(count), 3);
    $display("seq prescale: done after edge %0d, count=%0d", edges, count);

    // term=10, prescale=0, pause held for the four cycles at count 4.
    step(1, 1, 0, 0, 10, 0);
    edges = -1;
    for (int k = 1; k <= 40 && edges < 0; k++) begin
      step(1, 0, 0, (k >= 5 && k <= 8), 0, 0);
      if (k == 8) begin
        check("pause_frozen_count", int'(count), 4);
        check("pause_enb_low", int'(count_enb), 0);
      end
      if (done) edges = k - 1;
    end
    check("pause_done_edge", edges, 15);
    $display("seq pause: done after edge %0d", edges);

    // term=9, stop at count 2, then reset during a fresh run.
    step(1, 1, 0, 0, 9, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    check("stop_seen_count", int'(count), 2);
    step(1, 0, 0, 0, 0, 0);
    check("stop_busy", int'(busy), 0);
    check("stop_count_hold", int'(count), 2);
    step(1, 0, 0, 0, 0, 0);
    check("stop_no_done", int'(done), 0);
    step(1, 1, 0, 0, 9, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("midreset_count", int'(count), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_done", int'(done), 0);
    $display("seq stop/reset: count=%0d busy=%0d", count, busy);

    // term=255: full range without wrap.
    step(1, 1, 0, 0, 255, 0);
    edges = -1;
    for (int k = 1; k <= 300 && edges < 0; k++) begin
      step(1, 0, 0, 0, 0, 0);
      if (done) edges = k - 1;
    end
    check("full_done_edge", edges, 256);
    check("full_count_at_done", int'(count), 255);
    step(1, 0, 0, 0, 0, 0);
    check("full_no_wrap", int'(count), 255);
    check("full_busy_low", int'(busy), 0);
    $display("seq term255: done after edge %0d, count=%0d", edges, count);

`ifdef CNT_CTRL_AUTO_RELOAD_EN
    ar_drv = 1'b1;
    step(1, 1, 0, 0, 2, 0);
    pulses = 0;
    for (int k = 1; k <= 13; k++) begin
      step(1, 0, 0, 0, 0, 0);
      check("reload_busy", int'(busy), 1);
      check("reload_done_phase", int'(done), int'(k > 1 && ((k - 1) % 3) == 0));
      if (done) pulses++;
    end
    check("reload_pulses", pulses, 4);
    step(1, 0, 1, 0, 0, 0);
    ar_drv = 1'b0;
    step(1, 0, 0, 0, 0, 0);
    $display("seq auto_reload: %0d done pulses", pulses);
`endif

    // Randomised run checked against the model every cycle.
    for (int n = 0; n < 800; n++) begin
      step(($urandom_range(99, 0) != 0),
           ($urandom_range(7, 0) == 0),
           ($urandom_range(29, 0) == 0),
           ($urandom_range(5, 0) == 0),
           int'($urandom_range(12, 0)),
           int'($urandom_range(3, 0)));
    end
    $display("random run: 800 cycles applied");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
